imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 149 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry skid buffer between the decode input and the consumer.
// The immediate is computed at accept time, so out_imm depends only on registered state.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no entries held, out_valid=0
// ST_ONE   | main register M holds the output entry
// ST_FULL  | M holds the output entry, skid K holds the next one
module imm_gen_pipe #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [2:0]      in_sel,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic            out_err,
   output logic            err_sticky
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] m_imm_q, m_imm_d;
   logic            m_err_q, m_err_d;
   logic [XLEN-1:0] k_imm_q, k_imm_d;
   logic            k_err_q, k_err_d;
   logic            err_sticky_q, err_sticky_d;

   logic [63:0]     imm_full;
   logic [XLEN-1:0] imm_new;
   logic            err_new;
   logic            accept;
   logic            pop;
   logic            unused_bits;

   // Built at 64 bits and truncated so one decoder serves both XLEN settings.
   always_comb begin
      imm_full = 64'd0;
      err_new  = 1'b0;
      case (in_sel)
         3'b000: begin
            if (in_inst[14:12] == 3'b101 && in_inst[30])
               imm_full = {{(64-SHAMT_W){1'b0}}, in_inst[20 +: SHAMT_W]};
            else
               imm_full = {{52{in_inst[31]}}, in_inst[31:20]};
         end
         3'b001: imm_full = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         3'b010: imm_full = {{32{in_inst[31]}}, in_inst[31:12], 12'h000};
         3'b011: imm_full = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
         3'b100: imm_full = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
         3'b101: imm_full = {59'd0, in_inst[19:15]};
         default: begin
            imm_full = 64'd0;
            err_new  = 1'b1;
         end
      endcase
   end

   assign imm_new     = imm_full[XLEN-1:0];
   assign unused_bits = ^{in_inst[6:0], imm_full};

   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_imm   = m_imm_q;
   assign out_err   = m_err_q;
   assign err_sticky = err_sticky_q;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   always_comb begin
      state_d      = state_q;
      m_imm_d      = m_imm_q;
      m_err_d      = m_err_q;
      k_imm_d      = k_imm_q;
      k_err_d      = k_err_q;
      err_sticky_d = err_sticky_q;
      if (flush) begin
         // Accept in this cycle is dropped, so it must not reach err_sticky either.
         state_d = ST_EMPTY;
      end else begin
         if (accept && err_new)
            err_sticky_d = 1'b1;
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  m_imm_d = imm_new;
                  m_err_d = err_new;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  m_imm_d = imm_new;
                  m_err_d = err_new;
               end else if (accept) begin
                  state_d = ST_FULL;
                  k_imm_d = imm_new;
                  k_err_d = err_new;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_d = ST_ONE;
                  m_imm_d = k_imm_q;
                  m_err_d = k_err_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         m_imm_q      <= '0;
         m_err_q      <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         m_imm_q      <= m_imm_d;
         m_err_q      <= m_err_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   // Skid contents are only meaningful in ST_FULL, so they carry no reset.
   always_ff @(posedge clk) begin
      k_imm_q <= k_imm_d;
      k_err_q <= k_err_d;
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue-based reference with arithmetic immediate decoding.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = 32'd0;
   logic [2:0]  in_sel = 3'd0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready32, out_valid32, out_err32, err_sticky32;
   logic [31:0] out_imm32;
   logic        in_ready64, out_valid64, out_err64, err_sticky64;
   logic [63:0] out_imm64;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit [31:0] inst;
      bit [2:0]  sel;
   } ent_t;

   ent_t q[$];
   bit   m_sticky = 1'b0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .in_inst(in_inst), .in_sel(in_sel), .flush(flush),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_err(out_err32), .err_sticky(err_sticky32)
   );

   imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
      .in_inst(in_inst), .in_sel(in_sel), .flush(flush),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_err(out_err64), .err_sticky(err_sticky64)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decoder: reassemble the immediate numerically, then sign-adjust.
   function automatic logic [63:0] ref_imm(input bit [31:0] inst, input bit [2:0] sel,
                                           input int xlen, input int shamt_w,
                                           output bit err);
      longint x = longint'(inst);
      longint v = 0;
      err = 1'b0;
      case (sel)
         3'd0: begin
            if (((x >> 12) & 7) == 5 && ((x >> 30) & 1) == 1) begin
               v = (x >> 20) & ((longint'(1) << shamt_w) - 1);
            end else begin
               v = (x >> 20) & 'hFFF;
               if (v >= 2048) v -= 4096;
            end
         end
         3'd1: begin
            v = (((x >> 25) & 127) << 5) | ((x >> 7) & 31);
            if (v >= 2048) v -= 4096;
         end
         3'd2: begin
            v = x & 'hFFFFF000;
            if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
         end
         3'd3: begin
            v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
            if (v >= 4096) v -= 8192;
         end
         3'd4: begin
            v = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
            if (v >= (1 << 20)) v -= (1 << 21);
         end
         3'd5: v = (x >> 15) & 31;
         default: begin
            v = 0;
            err = 1'b1;
         end
      endcase
      if (xlen == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic compare_outputs();
      logic [63:0] e32, e64;
      bit er32, er64;
      chk("valid32", 64'(out_valid32), 64'(q.size() != 0));
      chk("valid64", 64'(out_valid64), 64'(q.size() != 0));
      chk("ready32", 64'(in_ready32), 64'(q.size() < 2));
      chk("ready64", 64'(in_ready64), 64'(q.size() < 2));
      chk("sticky32", 64'(err_sticky32), 64'(m_sticky));
      chk("sticky64", 64'(err_sticky64), 64'(m_sticky));
      if (q.size() > 0) begin
         e32 = ref_imm(q[0].inst, q[0].sel, 32, 5, er32);
         e64 = ref_imm(q[0].inst, q[0].sel, 64, 6, er64);
         chk("imm32", 64'(out_imm32), e32);
         chk("imm64", out_imm64, e64);
         chk("err32", 64'(out_err32), 64'(er32));
         chk("err64", 64'(out_err64), 64'(er64));
      end
   endtask

   // One clock: check registered outputs, drive inputs, advance model at the edge.
   task automatic step(input bit r, input bit v, input bit [31:0] inst, input bit [2:0] sel,
                       input bit fl, input bit ordy);
      bit acc, pp;
      ent_t e;
      compare_outputs();
      rst = r; in_valid = v; in_inst = inst; in_sel = sel; flush = fl; out_ready = ordy;
      @(posedge clk);
      acc = v && (q.size() < 2);
      pp  = ordy && (q.size() > 0);
      if (r) begin
         q.delete();
         m_sticky = 1'b0;
      end else if (fl) begin
         q.delete();
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            e.inst = inst;
            e.sel  = sel;
            q.push_back(e);
            if (sel >= 3'd6) m_sticky = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bit [31:0] ri;
      bit [2:0]  rs;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);

      // Reset state
      step(1, 0, 0, 0, 0, 0);
      chk("rst_imm32", 64'(out_imm32), 64'd0);
      chk("rst_imm64", out_imm64, 64'd0);
      chk("rst_err32", 64'(out_err32), 64'd0);
      chk("rst_ready", 64'(in_ready32), 64'd1);

      // Single-cycle latency and known immediates
      step(0, 1, 32'hFFF00093, 3'd0, 0, 1);
      chk("addi_m1_valid", 64'(out_valid32), 64'd1);
      chk("addi_m1_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
      chk("addi_m1_err", 64'(out_err32), 64'd0);
      step(0, 1, 32'h40315093, 3'd0, 0, 1);
      chk("srai3_imm32", 64'(out_imm32), 64'h3);
      chk("srai3_imm64", out_imm64, 64'h3);
      step(0, 1, 32'hFE20AE23, 3'd1, 0, 1);
      chk("sw_m4_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
      chk("sw_m4_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 1, 32'h800000B7, 3'd2, 0, 1);
      chk("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
      chk("lui_imm32", 64'(out_imm32), 64'h8000_0000);
      step(0, 1, 32'h0000006F, 3'd4, 0, 1);
      chk("jal0_imm64", out_imm64, 64'd0);
      step(0, 0, 0, 0, 0, 1);

      // Back-pressure: A and B fill, C is held until space opens
      step(0, 1, 32'h00100093, 3'd0, 0, 0);
      step(0, 1, 32'h00200093, 3'd0, 0, 0);
      chk("full_ready", 64'(in_ready32), 64'd0);
      step(0, 1, 32'h00300093, 3'd0, 0, 0);
      chk("stall_imm_a", 64'(out_imm32), 64'd1);
      step(0, 1, 32'h00300093, 3'd0, 0, 1);
      chk("order_b", 64'(out_imm32), 64'd2);
      step(0, 1, 32'h00300093, 3'd0, 0, 1);
      chk("order_c", 64'(out_imm32), 64'd3);
      step(0, 0, 0, 0, 0, 1);
      chk("drained", 64'(out_valid32), 64'd0);

      // Illegal select, then flush while full
      step(0, 1, 32'h12345678, 3'd6, 0, 0);
      chk("illegal_imm", 64'(out_imm32), 64'd0);
      chk("illegal_err", 64'(out_err32), 64'd1);
      chk("illegal_sticky", 64'(err_sticky32), 64'd1);
      step(0, 1, 32'h00500093, 3'd0, 0, 0);
      step(0, 1, 32'hABCDE123, 3'd7, 1, 1);
      chk("flush_valid", 64'(out_valid32), 64'd0);
      chk("flush_sticky", 64'(err_sticky64), 64'd1);
      step(0, 0, 0, 0, 0, 1);

      // Reset while full with in_valid high
      step(0, 1, 32'h00700093, 3'd0, 0, 0);
      step(0, 1, 32'h00800093, 3'd0, 0, 0);
      step(1, 1, 32'h00900093, 3'd0, 0, 0);
      chk("rstfull_valid", 64'(out_valid32), 64'd0);
      chk("rstfull_ready", 64'(in_ready32), 64'd1);
      chk("rstfull_sticky", 64'(err_sticky32), 64'd0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         ri = $urandom;
         rs = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            ri[14:12] = 3'b101;
            ri[30]    = 1'b1;
            rs        = 3'd0;
         end
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, ri, rs,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
      end
      compare_outputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
